// File: rtl/axis_vip_pkg.sv
// Shared types and helpers for the AXI-Stream sink monitor.
//   ready_mode_e   : backpressure pattern selector driven on ready_mode
//   LFSR_TAPS      : feedback mask for the 16-bit Fibonacci LFSR (taps 16,14,13,11)
//   count_words    : number of set bits in a keep vector (up to MAX_WORDS)
//   keep_is_prefix : keep is non-zero and contiguous from bit 0
package axis_vip_pkg;

  typedef enum logic [1:0] {
    READY_ALWAYS   = 2'd0,
    READY_RANDOM   = 2'd1,
    READY_PERIODIC = 2'd2,
    READY_HOLD     = 2'd3
  } ready_mode_e;

  // Bits 15,13,12,10 in zero-based indexing.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Widest keep vector the helpers handle; callers zero-extend to this.
  localparam int MAX_WORDS = 32;

  function automatic logic [31:0] count_words(input logic [MAX_WORDS-1:0] keep);
    logic [31:0] n;
    n = '0;
    for (int i = 0; i < MAX_WORDS; i++) begin
      n = n + 32'(keep[i]);
    end
    return n;
  endfunction

  // A prefix mask 0..01..1 has no carry into a set bit when incremented.
  function automatic logic keep_is_prefix(input logic [MAX_WORDS-1:0] keep);
    return (keep != '0) && ((keep & (keep + 32'd1)) == '0);
  endfunction

endpackage

// File: rtl/axis_lfsr.sv
// 16-bit Fibonacci LFSR used as the random source for the ready generator.
//   clk   : clock, rising edge
//   rstn  : synchronous active-low reset, loads SEED (0 is replaced by 1)
//   en    : advance one step this cycle
//   value : low OUT_W bits of the current LFSR state
module axis_lfsr
  import axis_vip_pkg::*;
#(
  parameter logic [15:0] SEED  = 16'hACE1,
  parameter int          OUT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  output logic [OUT_W-1:0] value
);

  // An all-zero state would lock the LFSR up forever.
  localparam logic [15:0] SEED_EFF = (SEED == 16'd0) ? 16'd1 : SEED;

  logic [15:0] state;
  logic        feedback;

  assign feedback = ^(state & LFSR_TAPS);
  assign value    = state[OUT_W-1:0];

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= SEED_EFF;
    end else if (en) begin
      state <= {state[14:0], feedback};
    end
  end

endmodule

// File: rtl/axis_sink_mon.sv
// AXI-Stream sink with programmable backpressure and a protocol monitor.
//   clk, rstn      : clock (rising edge) and synchronous active-low reset
//   ready_mode     : 0 always ready, 1 random, 2 periodic, 3 hold-off
//   clear          : one-cycle pulse, zeroes pkt_count and sticky errors
//   m_valid/m_last : upstream beat valid / last beat of packet
//   m_keep, m_data : per-word valid mask and packed beat payload
//   m_ready        : registered backpressure toward upstream
//   pkt_done       : one-cycle pulse after a last beat is accepted
//   pkt_count      : completed packets (wraps)
//   last_pkt_words : kept-word count of the most recent packet
//   err_stable     : payload changed while stalled (sticky)
//   err_valid_drop : valid dropped while stalled (sticky)
//   err_keep       : accepted beat with zero or non-prefix keep (sticky)
module axis_sink_mon
  import axis_vip_pkg::*;
#(
  parameter  int          WORD_W         = 8,
  parameter  int          BUS_W          = 32,
  parameter  int          PROB_READY     = 20,
  parameter  int          PERIOD         = 4,
  parameter  logic [15:0] SEED           = 16'hACE1,
  localparam int          WORDS_PER_BEAT = BUS_W / WORD_W
) (
  input  logic                                   clk,
  input  logic                                   rstn,
  input  logic [1:0]                             ready_mode,
  input  logic                                   clear,
  input  logic                                   m_valid,
  input  logic                                   m_last,
  input  logic [WORDS_PER_BEAT-1:0]              m_keep,
  input  logic [WORDS_PER_BEAT-1:0][WORD_W-1:0]  m_data,
  output logic                                   m_ready,
  output logic                                   pkt_done,
  output logic [31:0]                            pkt_count,
  output logic [31:0]                            last_pkt_words,
  output logic                                   err_stable,
  output logic                                   err_valid_drop,
  output logic                                   err_keep
);

  // 7 random bits against a 0..128 threshold: 100% gives 128 (always true),
  // 0% gives 0 (never true).
  localparam int          THRESH   = (PROB_READY * 128) / 100;
  localparam logic [7:0]  THRESH_V = 8'(THRESH);

  localparam int                 CNT_W    = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(PERIOD - 1);

  ready_mode_e       mode;
  logic [6:0]        rnd;
  logic [CNT_W-1:0]  per_cnt;
  logic              ready_next;

  logic              accept;
  logic              accept_last;
  logic [31:0]       beat_words;
  logic [31:0]       run_words;

  logic                                  stall_q;
  logic                                  last_q;
  logic [WORDS_PER_BEAT-1:0]             keep_q;
  logic [WORDS_PER_BEAT-1:0][WORD_W-1:0] data_q;

  logic              det_stable;
  logic              det_valid_drop;
  logic              det_keep;

  assign mode = ready_mode_e'(ready_mode);

  axis_lfsr #(
    .SEED  (SEED),
    .OUT_W (7)
  ) u_lfsr (
    .clk   (clk),
    .rstn  (rstn),
    .en    (mode == READY_RANDOM),
    .value (rnd)
  );

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    ready_next = 1'b0;
    unique case (mode)
      READY_ALWAYS:   ready_next = 1'b1;
      READY_RANDOM:   ready_next = ({1'b0, rnd} < THRESH_V);
      READY_PERIODIC: ready_next = (per_cnt == '0);
      READY_HOLD:     ready_next = 1'b0;
      default:        ready_next = 1'b0;
    endcase
  end

  assign accept      = m_valid && m_ready;
  assign accept_last = accept && m_last;
  assign beat_words  = count_words(MAX_WORDS'(m_keep));

  // A stall in the previous cycle obliges upstream to hold valid and payload.
  assign det_valid_drop = stall_q && !m_valid;
  assign det_stable     = stall_q && ((m_data != data_q) || (m_keep != keep_q) ||
                                      (m_last != last_q));
  assign det_keep       = accept && !keep_is_prefix(MAX_WORDS'(m_keep));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      m_ready        <= 1'b0;
      per_cnt        <= '0;
      pkt_done       <= 1'b0;
      pkt_count      <= '0;
      last_pkt_words <= '0;
      run_words      <= '0;
      stall_q        <= 1'b0;
      err_stable     <= 1'b0;
      err_valid_drop <= 1'b0;
      err_keep       <= 1'b0;
    end else begin
      m_ready  <= ready_next;
      per_cnt  <= (per_cnt == CNT_LAST) ? '0 : per_cnt + 1'b1;
      pkt_done <= accept_last;
      stall_q  <= m_valid && !m_ready;

      if (accept) begin
        if (m_last) begin
          last_pkt_words <= run_words + beat_words;
          run_words      <= '0;
        end else begin
          run_words <= run_words + beat_words;
        end
      end

      // A last beat accepted alongside clear counts as the first new packet.
      if (clear) begin
        pkt_count <= accept_last ? 32'd1 : 32'd0;
      end else if (accept_last) begin
        pkt_count <= pkt_count + 32'd1;
      end

      err_stable     <= (err_stable     && !clear) || det_stable;
      err_valid_drop <= (err_valid_drop && !clear) || det_valid_drop;
      err_keep       <= (err_keep       && !clear) || det_keep;
    end
  end

  // NOTE: the payload history is left out of reset on purpose; it is only
  // looked at when stall_q is set, and stall_q itself is reset.
  always_ff @(posedge clk) begin
    data_q <= m_data;
    keep_q <= m_keep;
    last_q <= m_last;
  end

endmodule

// File: tb/tb_axis_sink_mon.sv
// Randomized and directed bench for axis_sink_mon with a transaction-level
// reference model. A second instance (PROB_READY=100, PERIOD=1) covers the
// always-ready corner of the random and periodic generators.
module tb_axis_sink_mon;

  logic        clk = 1'b0;
  logic        rstn;
  logic [1:0]  ready_mode;
  logic        clear;
  logic        m_valid;
  logic        m_last;
  logic [3:0]  m_keep;
  logic [31:0] m_data;

  logic        m_ready, pkt_done, err_stable, err_valid_drop, err_keep;
  logic [31:0] pkt_count, last_pkt_words;

  logic        f_m_ready, f_pkt_done, f_err_stable, f_err_valid_drop, f_err_keep;
  logic [31:0] f_pkt_count, f_last_pkt_words;

  always #5 clk = ~clk;

  axis_sink_mon dut (
    .clk            (clk),
    .rstn           (rstn),
    .ready_mode     (ready_mode),
    .clear          (clear),
    .m_valid        (m_valid),
    .m_last         (m_last),
    .m_keep         (m_keep),
    .m_data         (m_data),
    .m_ready        (m_ready),
    .pkt_done       (pkt_done),
    .pkt_count      (pkt_count),
    .last_pkt_words (last_pkt_words),
    .err_stable     (err_stable),
    .err_valid_drop (err_valid_drop),
    .err_keep       (err_keep)
  );

  axis_sink_mon #(.PROB_READY(100), .PERIOD(1)) dut_full (
    .clk            (clk),
    .rstn           (rstn),
    .ready_mode     (ready_mode),
    .clear          (clear),
    .m_valid        (m_valid),
    .m_last         (m_last),
    .m_keep         (m_keep),
    .m_data         (m_data),
    .m_ready        (f_m_ready),
    .pkt_done       (f_pkt_done),
    .pkt_count      (f_pkt_count),
    .last_pkt_words (f_last_pkt_words),
    .err_stable     (f_err_stable),
    .err_valid_drop (f_err_valid_drop),
    .err_keep       (f_err_keep)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model state: what the outputs must be after the next edge.
  logic        e_rdy = 1'b0, e_rdy_known = 1'b0;
  logic        f_rdy = 1'b0, f_rdy_known = 1'b0;
  logic        e_done = 1'b0, e_es = 1'b0, e_ed = 1'b0, e_ek = 1'b0;
  logic [31:0] e_cnt = '0, e_lastw = '0, e_run = '0;
  int          edges_since_reset = 0;
  logic        p_stall = 1'b0, p_last = 1'b0;
  logic [3:0]  p_keep = '0;
  logic [31:0] p_data = '0;

  logic        last_rdy, last_frdy, last_acc;
  int          done_pulses = 0;

  // One clock: feed current inputs to the model, take the edge, compare.
  task automatic cycle();
    logic rdy, acc, acc_last, det_drop, det_stable, keep_bad;
    int   words;
    rdy = m_ready;
    if (e_rdy_known) check("m_ready", 32'(m_ready), 32'(e_rdy));
    if (f_rdy_known) check("full_m_ready", 32'(f_m_ready), 32'(f_rdy));
    acc       = m_valid && rdy;
    last_rdy  = rdy;
    last_frdy = f_m_ready;
    last_acc  = acc;
    if (!rstn) begin
      e_done = 0; e_cnt = 0; e_lastw = 0; e_run = 0;
      e_es = 0; e_ed = 0; e_ek = 0;
      edges_since_reset = 0;
      p_stall = 0;
      e_rdy = 0; e_rdy_known = 1;
      f_rdy = 0; f_rdy_known = 1;
      last_acc = 0;
    end else begin
      words      = $countones(m_keep);
      acc_last   = acc && m_last;
      det_drop   = p_stall && !m_valid;
      det_stable = p_stall && (m_data !== p_data || m_keep !== p_keep || m_last !== p_last);
      keep_bad   = acc && !(m_keep inside {4'b0001, 4'b0011, 4'b0111, 4'b1111});
      e_es = (e_es && !clear) || det_stable;
      e_ed = (e_ed && !clear) || det_drop;
      e_ek = (e_ek && !clear) || keep_bad;
      if (clear) e_cnt = acc_last ? 32'd1 : 32'd0;
      else if (acc_last) e_cnt = e_cnt + 32'd1;
      if (acc) begin
        if (m_last) begin
          e_lastw = e_run + 32'(words);
          e_run   = 0;
        end else begin
          e_run = e_run + 32'(words);
        end
      end
      e_done = acc_last;
      case (ready_mode)
        2'd0: begin e_rdy = 1; e_rdy_known = 1; end
        2'd1: e_rdy_known = 0;
        2'd2: begin e_rdy = (edges_since_reset % 4 == 0); e_rdy_known = 1; end
        default: begin e_rdy = 0; e_rdy_known = 1; end
      endcase
      f_rdy = (ready_mode != 2'd3);
      f_rdy_known = 1;
      edges_since_reset++;
      p_stall = m_valid && !rdy;
      p_data  = m_data;
      p_keep  = m_keep;
      p_last  = m_last;
    end
    @(posedge clk);
    #1;
    done_pulses += int'(pkt_done);
    check("pkt_done", 32'(pkt_done), 32'(e_done));
    check("pkt_count", pkt_count, e_cnt);
    check("last_pkt_words", last_pkt_words, e_lastw);
    check("err_stable", 32'(err_stable), 32'(e_es));
    check("err_valid_drop", 32'(err_valid_drop), 32'(e_ed));
    check("err_keep", 32'(err_keep), 32'(e_ek));
  endtask

  task automatic idle(input int n);
    m_valid = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic send_beat(input logic [3:0] keep, input logic last, input logic [31:0] data);
    m_valid = 1'b1;
    m_keep  = keep;
    m_last  = last;
    m_data  = data;
    for (int i = 0; i < 64; i++) begin
      cycle();
      if (last_acc) return;
    end
    check("send_timeout", 32'(last_acc), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rc, frc, ac;
    rstn = 1'b0; ready_mode = 2'd0; clear = 1'b0;
    m_valid = 1'b0; m_last = 1'b0; m_keep = '0; m_data = '0;

    // Reset state.
    idle(2);
    check("reset_m_ready", 32'(m_ready), 32'd0);
    check("reset_pkt_count", pkt_count, 32'd0);

    // Always-ready: packets of 5, 8 and 1 words.
    rstn = 1'b1;
    idle(1);
    done_pulses = 0;
    send_beat(4'b1111, 1'b0, 32'h0101_0101);
    send_beat(4'b0001, 1'b1, 32'h0202_0202);
    send_beat(4'b1111, 1'b0, 32'h0303_0303);
    send_beat(4'b1111, 1'b1, 32'h0404_0404);
    send_beat(4'b0001, 1'b1, 32'h0505_0505);
    idle(2);
    check("three_pkts_count", pkt_count, 32'd3);
    check("three_pkts_last_words", last_pkt_words, 32'd1);
    check("three_pkts_done_pulses", 32'(done_pulses), 32'd3);
    check("three_pkts_errors", {29'd0, err_stable, err_valid_drop, err_keep}, 32'd0);

    // Periodic: 40 cycles of held valid, one in four ready.
    ready_mode = 2'd2;
    idle(1);
    m_valid = 1'b1; m_keep = 4'b1111; m_last = 1'b1; m_data = 32'hCAFE_F00D;
    rc = 0; ac = 0; frc = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      rc  += int'(last_rdy);
      ac  += int'(last_acc);
      frc += int'(last_frdy);
    end
    check("periodic_ready_cycles", 32'(rc), 32'd10);
    check("periodic_beats", 32'(ac), 32'd10);
    check("period1_ready_cycles", 32'(frc), 32'd40);
    for (int i = 0; i < 8 && !last_acc; i++) cycle();
    idle(1);

    // Random: 10000 cycles of protocol-correct random traffic.
    ready_mode = 2'd1;
    idle(1);
    rc = 0; frc = 0;
    for (int i = 0; i < 10000; i++) begin
      if (!m_valid || last_acc) begin
        m_valid = ($urandom_range(0, 3) != 0);
        m_keep  = 4'((1 << $urandom_range(1, 4)) - 1);
        m_last  = ($urandom_range(0, 3) == 0);
        m_data  = $urandom;
      end
      cycle();
      rc  += int'(last_rdy);
      frc += int'(last_frdy);
    end
    check("random_ready_fraction_ok", 32'(rc >= 1500 && rc <= 2500), 32'd1);
    check("random_full_ready_cycles", 32'(frc), 32'd10000);
    for (int i = 0; i < 400 && m_valid && !last_acc; i++) cycle();
    idle(1);

    // Hold-off: upstream changes data, then drops valid, during a stall.
    ready_mode = 2'd3;
    idle(2);
    m_valid = 1'b1; m_keep = 4'b1111; m_last = 1'b0; m_data = 32'h1111_1111;
    cycle();
    m_data = 32'h2222_2222;
    cycle();
    m_valid = 1'b0;
    cycle();
    check("stall_err_stable", 32'(err_stable), 32'd1);
    check("stall_err_valid_drop", 32'(err_valid_drop), 32'd1);
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    check("clear_err_stable", 32'(err_stable), 32'd0);
    check("clear_err_valid_drop", 32'(err_valid_drop), 32'd0);

    // Clear together with a last beat carrying a holey keep.
    ready_mode = 2'd0;
    idle(2);
    send_beat(4'b1111, 1'b1, 32'h3333_3333);
    clear = 1'b1;
    send_beat(4'b0101, 1'b1, 32'h4444_4444);
    clear = 1'b0;
    idle(1);
    check("clear_with_last_count", pkt_count, 32'd1);
    check("holey_keep_err", 32'(err_keep), 32'd1);
    check("holey_keep_words", last_pkt_words, 32'd2);

    // Reset mid-packet after a stall, then a fresh 2-word packet.
    send_beat(4'b1111, 1'b0, 32'h5555_5555);
    ready_mode = 2'd3;
    send_beat(4'b0011, 1'b0, 32'h6666_6666);
    m_data = 32'h7777_7777;
    cycle();
    rstn = 1'b0; m_valid = 1'b0;
    cycle();
    rstn = 1'b1; ready_mode = 2'd0;
    cycle();
    check("post_reset_errors", {29'd0, err_stable, err_valid_drop, err_keep}, 32'd0);
    send_beat(4'b0011, 1'b1, 32'h8888_8888);
    idle(2);
    check("post_reset_last_words", last_pkt_words, 32'd2);
    check("post_reset_count", pkt_count, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axis_sink_mon.md
AXIS_SINK_MON -- requirements
Module: axis_sink_mon

Interface
REQ-001 The block SHALL have parameter WORD_W, default 8, meaning bits per word.
REQ-002 The block SHALL have parameter BUS_W, default 32, meaning data bus bits; WORDS_PER_BEAT = BUS_W/WORD_W (derived).
REQ-003 The block SHALL have parameter PROB_READY, default 20, meaning percent (0..100) probability of ready in random mode.
REQ-004 The block SHALL have parameter PERIOD, default 4, meaning ready asserted 1 of every PERIOD cycles in periodic mode (PERIOD>=1).
REQ-005 The block SHALL have parameter SEED, default 16'hACE1, meaning LFSR reset value; 0 SHALL be replaced by 1.
REQ-006 The block SHALL have port clk, input, 1, meaning the single clock; all logic rising-edge.
REQ-007 The block SHALL have port rstn, input, 1, meaning reset, synchronous and active-low.
REQ-008 The block SHALL have port ready_mode, input, 2, meaning 0 always, 1 random, 2 periodic, 3 hold-off.
REQ-009 The block SHALL have port clear, input, 1, meaning a one-cycle pulse that clears sticky errors and pkt_count.
REQ-010 The block SHALL have port m_valid, input, 1, meaning the upstream beat valid.
REQ-011 The block SHALL have port m_last, input, 1, meaning last beat of packet.
REQ-012 The block SHALL have port m_keep, input, WORDS_PER_BEAT, meaning per-word valid.
REQ-013 The block SHALL have port m_data, input, WORDS_PER_BEAT x WORD_W packed, meaning the beat payload.
REQ-014 The block SHALL have port m_ready, output, 1, meaning registered backpressure.
REQ-015 The block SHALL have port pkt_done, output, 1, meaning a one-cycle pulse the cycle after a last beat is accepted.
REQ-016 The block SHALL have port pkt_count, output, 32, meaning completed packets, wrapping mod 2^32.
REQ-017 The block SHALL have port last_pkt_words, output, 32, meaning the kept-word count of the most recent packet.
REQ-018 The block SHALL have port err_stable, err_valid_drop, err_keep, output, 1 each, meaning sticky protocol errors.

Function
REQ-019 A beat SHALL be accepted at a rising edge where m_valid && m_ready; no other edge changes counters.
REQ-020 m_ready SHALL be a flop; its next value SHALL be computed from ready_mode sampled in the current cycle (mode change effective next cycle, mid-packet allowed).
REQ-021 Mode 0: m_ready next = 1; mode 3: m_ready next = 0.
REQ-022 Mode 1: a 16-bit Fibonacci LFSR (taps 16,14,13,11) SHALL advance every cycle; m_ready next = (lfsr[6:0] < THRESH), THRESH = (PROB_READY*128)/100; PROB_READY=100 forces 1, 0 forces 0.
REQ-023 Mode 2: a counter 0..PERIOD-1 SHALL wrap every cycle; m_ready next = (counter==0); PERIOD=1 yields always ready.
REQ-024 Per accepted beat, the running word count SHALL add popcount(m_keep), 0..WORDS_PER_BEAT.
REQ-025 On an accepted beat with m_last: last_pkt_words SHALL load running count + popcount(m_keep); running count SHALL reset to 0; pkt_count SHALL increment; pkt_done SHALL pulse next cycle.
REQ-026 Running count SHALL be 32 bits, wrapping mod 2^32.
REQ-027 err_valid_drop SHALL set when the prior cycle had m_valid && !m_ready and the current cycle has !m_valid.
REQ-028 err_stable SHALL set when the prior cycle had m_valid && !m_ready and m_data, m_keep or m_last differ in the current cycle.
REQ-029 err_keep SHALL set on an accepted beat whose m_keep is zero or not contiguous from bit 0.
REQ-030 clear SHALL zero pkt_count and all err_* next cycle; if clear coincides with a last-beat acceptance, pkt_count SHALL become 1 and errors detected that cycle SHALL still set.
REQ-031 last_pkt_words SHALL be unaffected by clear.

Reset
REQ-032 While rstn=0 at an edge: m_ready=0, pkt_done=0, pkt_count=0, last_pkt_words=0, err_*=0, running count=0, period counter=0, LFSR=SEED.
REQ-033 Reset mid-packet SHALL discard the partial count; the stall history flop SHALL clear so no error fires on the first post-reset cycle.

Structure
REQ-034 Package axis_vip_pkg SHALL hold the ready_mode enum (READY_ALWAYS, READY_RANDOM, READY_PERIODIC, READY_HOLD) and LFSR tap constant.
REQ-035 One sub-module, axis_lfsr (16-bit, seed parameter, enable), SHALL provide the random source.

Verification
REQ-036 Mode 0, 3 packets of 5/8/1 words, BUS_W=32, tail keep 4'b0001 -> pkt_count=3, last_pkt_words=1, 3 pkt_done pulses, no errors.
REQ-037 Mode 2, PERIOD=4, valid held high 40 cycles -> m_ready high exactly 10 cycles, 10 beats accepted.
REQ-038 Mode 1, PROB_READY=20, 10000 cycles -> ready fraction 15-25%; PROB_READY=100 -> 100%.
REQ-039 Upstream drops valid and changes data during stall -> err_valid_drop=1 and err_stable=1; clear pulse -> both 0 next cycle.
REQ-040 Accepted beat with keep 4'b0101 -> err_keep=1; rstn low mid-packet, then 2-word packet -> last_pkt_words=2.
